// File: rtl/picorv32_soc_avalon_mutex_bank_pkg.sv
// Shared constants and helpers for the Avalon-MM hardware mutex bank.
package picorv32_soc_avalon_mutex_bank_pkg;

    localparam int BUS_W = 32;

    localparam int STAT_RESET   = 0;
    localparam int STAT_EXPIRED = 1;
    localparam int STAT_PENDING = 2;
    localparam int STAT_IRQEN   = 3;

    localparam int VALUE_LSB = 0;
    localparam int OWNER_LSB = 16;

    typedef struct packed {
        logic irq_en;
        logic pending;
        logic expired;
    } mutex_flags_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/picorv32_soc_avalon_mutex_bank_cell.sv
// One mutex: value/owner lock with owner check, optional lease timeout and status flags.
module picorv32_soc_avalon_mutex_cell
    import picorv32_soc_avalon_mutex_bank_pkg::*;
#(
    parameter int VALUE_W      = 16,
    parameter int OWNER_W      = 16,
    parameter int LEASE_CYCLES = 0,
    parameter int LEASE_W      = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mutex_we,
    input  logic               status_we,
    input  logic [BUS_W-1:0]   wdata,
    output logic [VALUE_W-1:0] value,
    output logic [OWNER_W-1:0] owner,
    output mutex_flags_t       flags
);

    localparam bit LEASE_EN = (LEASE_CYCLES > 0);
    localparam logic [LEASE_W-1:0] LEASE_RELOAD =
        LEASE_EN ? LEASE_W'(LEASE_CYCLES - 1) : '0;

    logic [VALUE_W-1:0] value_q, value_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [LEASE_W-1:0] lease_cnt_q, lease_cnt_d;
    mutex_flags_t       flags_q, flags_d;

    logic [VALUE_W-1:0] wr_value;
    logic [OWNER_W-1:0] wr_owner;
    logic               locked;
    logic               accept;
    logic               owner_release;
    logic               expire;
    logic               unused_wdata;

    assign unused_wdata = ^wdata;

    always_comb begin
        wr_value      = wdata[VALUE_LSB +: VALUE_W];
        wr_owner      = wdata[OWNER_LSB +: OWNER_W];
        locked        = (value_q != '0);
        accept        = mutex_we && (!locked || (owner_q == wr_owner));
        owner_release = accept && locked && (wr_value == '0);
        // An accepted write on the expiry edge takes precedence over the lease.
        expire        = LEASE_EN && locked && !accept && (lease_cnt_q == '0);

        value_d     = value_q;
        owner_d     = owner_q;
        lease_cnt_d = lease_cnt_q;
        flags_d     = flags_q;

        if (accept) begin
            value_d = wr_value;
            owner_d = wr_owner;
            if (wr_value != '0) begin
                lease_cnt_d = LEASE_RELOAD;
            end
        end else if (expire) begin
            value_d = '0;
            owner_d = '0;
        end else if (LEASE_EN && locked) begin
            lease_cnt_d = lease_cnt_q - LEASE_W'(1);
        end

        if (status_we) begin
            if (wdata[STAT_EXPIRED]) begin
                flags_d.expired = 1'b0;
            end
            if (wdata[STAT_PENDING]) begin
                flags_d.pending = 1'b0;
            end
            flags_d.irq_en = wdata[STAT_IRQEN];
        end

        // Hardware set events are applied after the clears so they win a collision.
        if (expire) begin
            flags_d.expired = 1'b1;
        end
        if (expire || owner_release) begin
            flags_d.pending = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q     <= '0;
            owner_q     <= '0;
            lease_cnt_q <= '0;
            flags_q     <= '0;
        end else begin
            value_q     <= value_d;
            owner_q     <= owner_d;
            lease_cnt_q <= lease_cnt_d;
            flags_q     <= flags_d;
        end
    end

    assign value = value_q;
    assign owner = owner_q;
    assign flags = flags_q;

endmodule

// File: rtl/picorv32_soc_avalon_mutex_bank.sv
// Bank of NUM_MUTEX hardware mutexes behind one zero-wait Avalon-MM slave with release interrupt.
module picorv32_soc_avalon_mutex_bank
    import picorv32_soc_avalon_mutex_bank_pkg::*;
#(
    parameter  int NUM_MUTEX    = 4,
    parameter  int VALUE_W      = 16,
    parameter  int OWNER_W      = 16,
    parameter  int LEASE_CYCLES = 0,
    parameter  int LEASE_W      = 24,
    localparam int ADDR_W       = clog2(NUM_MUTEX) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [BUS_W-1:0]  data_from_cpu,
    output logic [BUS_W-1:0]  data_to_cpu,
    output logic              irq
);

    logic [ADDR_W-1:0]  idx;
    logic               is_status;
    logic               bus_we;
    logic               reset_reg_q, reset_reg_d;
    logic               unused_read;

    logic [VALUE_W-1:0] value_w [NUM_MUTEX];
    logic [OWNER_W-1:0] owner_w [NUM_MUTEX];
    mutex_flags_t       flags_w [NUM_MUTEX];

    // Reads have no side effects, so the strobe is not needed for decode.
    assign unused_read = read;

    assign idx       = address >> 1;
    assign is_status = address[0];
    assign bus_we    = chipselect && write;

    for (genvar g = 0; g < NUM_MUTEX; g++) begin : g_cell
        logic sel;
        assign sel = bus_we && (idx == ADDR_W'(g));

        picorv32_soc_avalon_mutex_cell #(
            .VALUE_W     (VALUE_W),
            .OWNER_W     (OWNER_W),
            .LEASE_CYCLES(LEASE_CYCLES),
            .LEASE_W     (LEASE_W)
        ) u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .mutex_we (sel && !is_status),
            .status_we(sel && is_status),
            .wdata    (data_from_cpu),
            .value    (value_w[g]),
            .owner    (owner_w[g]),
            .flags    (flags_w[g])
        );
    end

    // Any status write clears reset_reg, even one aimed at an unimplemented index.
    always_comb begin
        reset_reg_d = reset_reg_q;
        if (bus_we && is_status) begin
            reset_reg_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reset_reg_q <= 1'b1;
        end else begin
            reset_reg_q <= reset_reg_d;
        end
    end

    always_comb begin
        data_to_cpu = '0;
        irq         = 1'b0;
        for (int i = 0; i < NUM_MUTEX; i++) begin
            irq = irq | (flags_w[i].pending & flags_w[i].irq_en);
            if (idx == ADDR_W'(i)) begin
                if (is_status) begin
                    data_to_cpu[STAT_RESET]   = reset_reg_q;
                    data_to_cpu[STAT_EXPIRED] = flags_w[i].expired;
                    data_to_cpu[STAT_PENDING] = flags_w[i].pending;
                    data_to_cpu[STAT_IRQEN]   = flags_w[i].irq_en;
                end else begin
                    data_to_cpu = (BUS_W'(owner_w[i]) << OWNER_LSB)
                                | (BUS_W'(value_w[i]) << VALUE_LSB);
                end
            end
        end
    end

endmodule

// File: tb/tb_picorv32_soc_avalon_mutex_bank.sv
// Bench for the mutex bank: directed vector table, lease/collision sequences and random traffic vs a deadline-based model.
module tb_picorv32_soc_avalon_mutex_bank;

    localparam int N     = 3;
    localparam int LEASE = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] data_from_cpu;
    logic [31:0] data_to_cpu;
    logic        irq;

    always #5 clk = ~clk;

    picorv32_soc_avalon_mutex_bank #(
        .NUM_MUTEX   (N),
        .VALUE_W     (16),
        .OWNER_W     (16),
        .LEASE_CYCLES(LEASE),
        .LEASE_W     (24)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .data_from_cpu(data_from_cpu),
        .data_to_cpu  (data_to_cpu),
        .irq          (irq)
    );

    int total = 0;
    int bad   = 0;
    int now   = 0;

    // Reference model: lock deadline kept as an absolute edge number.
    logic [15:0] m_val [N];
    logic [15:0] m_own [N];
    int          m_dl  [N];
    bit          m_exp [N];
    bit          m_pend[N];
    bit          m_en  [N];
    bit          m_rr;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_val[i] = 0; m_own[i] = 0; m_dl[i] = 0;
            m_exp[i] = 0; m_pend[i] = 0; m_en[i] = 0;
        end
        m_rr = 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        int i;
        i = int'(a >> 1);
        if (i >= N) return 32'h0;
        if (a[0]) return {28'h0, m_en[i], m_pend[i], m_exp[i], m_rr};
        return {m_own[i], m_val[i]};
    endfunction

    function automatic bit m_irq();
        bit r;
        r = 0;
        for (int i = 0; i < N; i++) r = r | (m_pend[i] & m_en[i]);
        return r;
    endfunction

    function automatic void model_step(input bit cs, input bit wr, input logic [2:0] a,
                                       input logic [31:0] d);
        int  i;
        bit  wen, st, locked, acc, ex, rel;
        now++;
        i   = int'(a >> 1);
        st  = a[0];
        wen = cs && wr;
        if (wen && st) m_rr = 0;
        for (int k = 0; k < N; k++) begin
            locked = (m_val[k] != 0);
            acc    = wen && !st && (i == k) && (!locked || m_own[k] == d[31:16]);
            ex     = 0;
            rel    = 0;
            if (acc) begin
                if (locked && d[15:0] == 0) rel = 1;
                m_val[k] = d[15:0];
                m_own[k] = d[31:16];
                if (d[15:0] != 0) m_dl[k] = now + LEASE;
            end else if (locked && now == m_dl[k]) begin
                ex = 1;
                m_val[k] = 0;
                m_own[k] = 0;
            end
            if (wen && st && i == k) begin
                if (d[1]) m_exp[k] = 0;
                if (d[2]) m_pend[k] = 0;
                m_en[k] = d[3];
            end
            if (ex) begin
                m_exp[k]  = 1;
                m_pend[k] = 1;
            end
            if (rel) m_pend[k] = 1;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp_v);
        end
    endtask

    // One bus cycle: drive at negedge, compare just after, advance the model at posedge.
    task automatic tick(input bit cs, input bit wr, input logic [2:0] a, input logic [31:0] d,
                        input bit use_exp, input logic [31:0] exp_d, input bit exp_irq,
                        input string nm);
        @(negedge clk);
        chipselect    = cs;
        write         = cs && wr;
        read          = cs && !wr;
        address       = a;
        data_from_cpu = d;
        #1;
        chk({nm, "_model_rd"}, data_to_cpu, m_read(a));
        chk({nm, "_model_irq"}, {31'h0, irq}, {31'h0, m_irq()});
        if (use_exp) begin
            chk(nm, data_to_cpu, exp_d);
            chk({nm, "_irq"}, {31'h0, irq}, {31'h0, exp_irq});
        end
        @(posedge clk);
        model_step(cs, wr, a, d);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick(0, 0, 3'd0, 32'h0, 0, 32'h0, 0, "idle");
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        tick(1, 1, a, d, 0, 32'h0, 0, "wr");
    endtask

    task automatic bus_rd(input logic [2:0] a, input logic [31:0] e, input bit ei, input string nm);
        tick(1, 0, a, 32'h0, 1, e, ei, nm);
    endtask

    typedef struct {
        bit          wr;
        logic [2:0]  a;
        logic [31:0] d;
        bit          c;
        logic [31:0] e;
        bit          ei;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit wr, input logic [2:0] a, input logic [31:0] d, input bit c,
                       input logic [31:0] e, input bit ei, input string nm);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.c = c; v.e = e; v.ei = ei; v.nm = nm;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int          op;
        logic [2:0]  ra;
        logic [31:0] rd;

        reset_n = 1'b0; chipselect = 0; write = 0; read = 0;
        address = 0; data_from_cpu = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        add(0, 3'd1, 32'h0,        1, 32'h00000001, 0, "rst_stat0");
        add(0, 3'd0, 32'h0,        1, 32'h00000000, 0, "rst_mutex0");
        add(0, 3'd5, 32'h0,        1, 32'h00000001, 0, "rst_stat2");
        add(1, 3'd7, 32'hE,        0, 32'h0,        0, "oor_stat_wr");
        add(0, 3'd1, 32'h0,        1, 32'h00000000, 0, "rr_cleared");
        add(0, 3'd7, 32'h0,        1, 32'h00000000, 0, "oor_stat_rd");
        add(1, 3'd2, 32'h00AA0001, 0, 32'h0,        0, "acq1");
        add(1, 3'd2, 32'h00BB0005, 0, 32'h0,        0, "steal1");
        add(0, 3'd2, 32'h0,        1, 32'h00AA0001, 0, "owner_kept");
        add(0, 3'd3, 32'h0,        1, 32'h00000000, 0, "reject_noflag");
        add(1, 3'd2, 32'h00AA0000, 0, 32'h0,        0, "rel1");
        add(0, 3'd2, 32'h0,        1, 32'h00AA0000, 0, "rel1_rd");
        add(0, 3'd3, 32'h0,        1, 32'h00000004, 0, "rel1_pend");
        add(1, 3'd6, 32'h00110022, 0, 32'h0,        0, "oor_mut_wr");
        add(0, 3'd6, 32'h0,        1, 32'h00000000, 0, "oor_mut_rd");
        add(0, 3'd0, 32'h0,        1, 32'h00000000, 0, "m0_untouched");
        add(0, 3'd4, 32'h0,        1, 32'h00000000, 0, "m2_untouched");
        add(1, 3'd4, 32'h00CC0000, 0, 32'h0,        0, "free_wr0");
        add(0, 3'd4, 32'h0,        1, 32'h00CC0000, 0, "free_wr0_rd");
        add(0, 3'd5, 32'h0,        1, 32'h00000000, 0, "free_wr0_nopend");
        add(1, 3'd3, 32'h8,        0, 32'h0,        0, "irqen1");
        add(0, 3'd3, 32'h0,        1, 32'h0000000C, 1, "irq_rise");
        add(1, 3'd3, 32'hC,        0, 32'h0,        0, "w1c_pend1");
        add(0, 3'd3, 32'h0,        1, 32'h00000008, 0, "irq_fall");

        foreach (vecs[k]) begin
            tick(1, vecs[k].wr, vecs[k].a, vecs[k].d, vecs[k].c, vecs[k].e, vecs[k].ei, vecs[k].nm);
        end

        // Lease expiry exactly LEASE edges after acquisition.
        bus_wr(3'd4, 32'h00010007);
        idle(9);
        bus_rd(3'd4, 32'h00010007, 0, "lease_hold_t9");
        bus_rd(3'd4, 32'h00000000, 0, "lease_free_t10");
        bus_rd(3'd5, 32'h00000006, 0, "lease_stat");
        bus_wr(3'd5, 32'h6);

        // Renewal at T+5 moves expiry to T+15.
        bus_wr(3'd4, 32'h00010007);
        idle(4);
        bus_wr(3'd4, 32'h00010007);
        idle(4);
        bus_rd(3'd4, 32'h00010007, 0, "renew_old_deadline");
        idle(4);
        bus_rd(3'd4, 32'h00010007, 0, "renew_hold");
        bus_rd(3'd4, 32'h00000000, 0, "renew_free");
        bus_wr(3'd5, 32'h6);

        // Renewal on the exact expiry edge.
        bus_wr(3'd4, 32'h00010007);
        idle(9);
        bus_wr(3'd4, 32'h00010007);
        bus_rd(3'd4, 32'h00010007, 0, "coll_hold");
        bus_rd(3'd5, 32'h00000000, 0, "coll_noexp");
        idle(7);
        bus_rd(3'd4, 32'h00010007, 0, "coll_reload");
        bus_rd(3'd4, 32'h00000000, 0, "coll_expire");
        bus_wr(3'd5, 32'h6);

        // Expiry-driven release coinciding with a W1C of the same flags.
        bus_wr(3'd2, 32'h00AA0001);
        idle(9);
        bus_wr(3'd3, 32'hE);
        bus_rd(3'd3, 32'h0000000E, 1, "set_wins");
        bus_wr(3'd3, 32'h6);
        bus_rd(3'd3, 32'h00000000, 0, "irq_off");

        // Owner release on the expiry edge is a plain release.
        bus_wr(3'd0, 32'h00050001);
        idle(9);
        bus_wr(3'd0, 32'h00050000);
        bus_rd(3'd1, 32'h00000004, 0, "rel_on_expiry");
        bus_rd(3'd0, 32'h00050000, 0, "rel_owner");
        bus_wr(3'd1, 32'h4);

        for (int k = 0; k < 600; k++) begin
            op = $urandom_range(0, 9);
            ra = 3'($urandom_range(0, 7));
            if (op <= 3) begin
                tick(1, 0, ra, 32'h0, 0, 32'h0, 0, "rnd_rd");
            end else if (op <= 6) begin
                rd = {16'($urandom_range(1, 2)), 16'($urandom_range(0, 3))};
                ra[0] = 1'b0;
                tick(1, 1, ra, rd, 0, 32'h0, 0, "rnd_mw");
            end else if (op == 7) begin
                rd = 32'($urandom_range(0, 15));
                ra[0] = 1'b1;
                tick(1, 1, ra, rd, 0, 32'h0, 0, "rnd_sw");
            end else begin
                tick(0, 0, ra, 32'h0, 0, 32'h0, 0, "rnd_idle");
            end
        end

        // Asynchronous reset in the middle of a lease.
        bus_wr(3'd1, 32'h8);
        bus_wr(3'd0, 32'h00030009);
        idle(3);
        @(negedge clk);
        chipselect = 0; write = 0; read = 0; address = 3'd0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_m0", data_to_cpu, 32'h0);
        chk("rst_mid_irq", {31'h0, irq}, 32'h0);
        address = 3'd1;
        #1;
        chk("rst_mid_stat0", data_to_cpu, 32'h00000001);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus_rd(3'd0, 32'h00000000, 0, "post_rst_m0");
        bus_rd(3'd1, 32'h00000001, 0, "post_rst_stat0");
        bus_wr(3'd1, 32'h0);
        bus_rd(3'd1, 32'h00000000, 0, "stat0_wr_clear");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/picorv32_soc_avalon_mutex_bank.md
# picorv32_soc_avalon_mutex_bank

Parametrised bank of NUM_MUTEX hardware mutexes behind a single Avalon-MM slave, for inter-master locking in the picorv32 SoC. Each mutex keeps the value/owner acquire semantics of the single mutex and adds:
- an optional lease timeout that force-releases a lock held too long;
- per-mutex expiry and release status flags;
- a maskable release interrupt.

Zero-wait-state reads; all state changes on accepted writes or lease expiry.

## Interface
- NUM_MUTEX, 4, number of mutexes (1..64)
- VALUE_W, 16, value field width (1..16)
- OWNER_W, 16, owner field width (1..16)
- LEASE_CYCLES, 0, lease length in clk cycles; 0 disables the lease timeout
- LEASE_W, 24, lease counter width; LEASE_CYCLES must be < 2**LEASE_W
- ADDR_W, derived as clog2(NUM_MUTEX)+1; not user-set

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  ADDR_W  word address: index i = address[ADDR_W-1:1]; address[0] = 0 selects the mutex register, 1 the status register
- chipselect  in  1  slave select
- read  in  1  read strobe; no side effects
- write  in  1  write strobe
- data_from_cpu  in  32  write data
- data_to_cpu  out  32  read data, combinational from address
- irq  out  1  level interrupt = OR over i of (release_pending[i] & irq_en[i])

## Operation
- Mutex register i (address[0] = 0):
  - Read returns {zero-extended owner in [31:16], zero-extended value in [15:0]}.
  - A write with chipselect is accepted iff value_i == 0 or owner_i == data_from_cpu[16+OWNER_W-1:16].
  - When accepted: value_i <= data_from_cpu[VALUE_W-1:0] and owner_i <= data_from_cpu owner field.
  - When rejected: the write is silently ignored and no flag is set.
- Locked means value_i != 0.
  - An accepted write with nonzero value acquires or renews the lock.
  - An accepted write of value 0 by the owner releases it.
- Lease (LEASE_CYCLES > 0 only):
  - An accepted nonzero write loads lease_cnt_i <= LEASE_CYCLES-1.
  - Each later edge while locked with no accepted write: if lease_cnt_i == 0, expire; else decrement.
  - Expire means value_i <= 0, owner_i <= 0, expired_i <= 1.
- release_pending_i is set on every locked-to-free transition, whether by owner release or by expiry.
- Status register i (address[0] = 1), read layout:
  - bit0: reset_reg (global, 1 after reset)
  - bit1: expired_i
  - bit2: release_pending_i
  - bit3: irq_en_i
  - bits [31:4]: 0
- Status register i, write behaviour:
  - Any status write clears reset_reg.
  - bit1 and bit2 are write-1-to-clear.
  - bit3 is loaded directly.
- Index i >= NUM_MUTEX: reads return 0; writes are ignored, except that a status write still clears reset_reg.
- Simultaneous events:
  - Accepted renewing write and expiry on the same edge: the write wins, the counter reloads, no expiry.
  - Flag set and write-1-to-clear on the same edge: set wins.
  - An owner release of 0 arriving on the expiry edge is a plain release: expired stays 0, pending is set.
- A write of value 0 to an already-free mutex is accepted: the owner field updates and pending is not set.

## Timing
- Reset (asynchronous assert): all value, owner, lease_cnt, expired, release_pending and irq_en = 0; reset_reg = 1; irq = 0.
- data_to_cpu follows address with zero latency; read waitrequest and latency are 0.
- Write effects are visible on the read port the cycle after the accepting edge.
- Lease: a lock accepted at edge T is freed at edge T+LEASE_CYCLES if not renewed.
- irq is combinational from registers: it rises the cycle after the flag-setting edge and falls the cycle after the clearing write.
- reset_n asserted mid-lease drops all locks immediately; no flags are set by reset.

## Structure
- A shared package or header holds:
  - status bit indices STAT_RESET = 0, STAT_EXPIRED = 1, STAT_PENDING = 2, STAT_IRQEN = 3;
  - field offsets VALUE_LSB = 0, OWNER_LSB = 16;
  - a clog2 function.
- Sub-module picorv32_soc_avalon_mutex_cell:
  - contents: one mutex's value, owner, lease counter, expired/pending/irq_en flags and accept logic;
  - instantiation: generated NUM_MUTEX times;
  - top-level duties: address decode, read mux, reset_reg and irq OR-reduction.

## Test plan
- Reset, then read status 0 -> 0x00000001; read mutex 0 -> 0x0; irq = 0. Write status 0 -> reads 0x00000000.
- Owner check:
  - Write mutex 1 = 0x00AA0001, then 0x00BB0005 -> reads 0x00AA0001 (rejected).
  - Write 0x00AA0000 -> reads 0x00AA0000; status 1 bit2 = 1.
- LEASE_CYCLES = 10:
  - Acquire mutex 2 at edge T -> still locked at T+9, reads 0x0 at T+10; status 2 = 0x6.
  - Renew at T+5 -> expiry moves to T+15.
- Collision: renew write on the exact expiry edge -> lock held, expired = 0, counter reloaded.
- Interrupt:
  - irq_en 3 = 1, release mutex 3 -> irq = 1 the next cycle.
  - W1C bit2 -> irq = 0.
  - Release again while writing W1C on the same edge -> pending stays 1.
- NUM_MUTEX = 3: access index 3 -> reads 0, writes leave all mutexes unchanged.
